// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide, one bit per cycle, stalling the pipeline while it works.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MulDivStartE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic [DATA_WIDTH-1:0] MulDivResultE,
  output logic                  MulDivDoneE,
  output logic                  MulDivStallE,
  output logic                  MulDivBusyE
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [W-1:0]    r_opnd;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_result;

  // Operand decode, only meaningful while IDLE
  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag, w_min;
  logic            w_div_zero, w_div_ovf, w_fast, w_accept;
  logic [W-1:0]    w_fast_result;

  assign w_is_div   = funct3E[2];
  assign w_a_signed = w_is_div ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~funct3E[0] : ~funct3E[1];
  assign w_a_neg    = w_a_signed & SrcAE[W-1];
  assign w_b_neg    = w_b_signed & SrcBE[W-1];
  assign w_a_mag    = w_a_neg ? (~SrcAE + 1'b1) : SrcAE;
  assign w_b_mag    = w_b_neg ? (~SrcBE + 1'b1) : SrcBE;
  assign w_min      = {1'b1, {(W-1){1'b0}}};

  assign w_div_zero = w_is_div & (SrcBE == '0);
  assign w_div_ovf  = w_is_div & ~funct3E[0] & (SrcAE == w_min) & (SrcBE == '1);
  assign w_fast     = w_div_zero | w_div_ovf;
  assign w_accept   = (r_state == S_IDLE) & MulDivStartE & ~FlushE;

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero)
      w_fast_result = funct3E[1] ? SrcAE : '1;
    else if (w_div_ovf)
      w_fast_result = funct3E[1] ? '0 : SrcAE;
  end

  // One iteration step. r_acc is {hi, lo}: product for multiply, {remainder, dividend/quotient} for divide
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_rem_shift;
  logic [W:0]      w_rem_diff;
  logic [2*W-1:0]  w_step;

  assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_rem_shift = r_acc[2*W-1:W-1];
  assign w_rem_diff  = w_rem_shift - {1'b0, r_opnd};

  always_comb begin
    w_step = r_acc;
    if (r_op[2]) begin
      if (!w_rem_diff[W])
        w_step = {w_rem_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else
        w_step = {w_rem_shift[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_step = {w_mul_sum, r_acc[W-1:1]};
    end
  end

  // Sign correction applied on the final step
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quot_fix, w_rem_fix, w_calc_result;

  assign w_prod_fix = r_neg_res ? (~w_step + 1'b1) : w_step;
  assign w_quot_fix = r_neg_res ? (~w_step[W-1:0] + 1'b1) : w_step[W-1:0];
  assign w_rem_fix  = r_neg_rem ? (~w_step[2*W-1:W] + 1'b1) : w_step[2*W-1:W];

  always_comb begin
    w_calc_result = '0;
    if (r_op[2])
      w_calc_result = r_op[1] ? w_rem_fix : w_quot_fix;
    else
      w_calc_result = (r_op[1:0] == 2'b00) ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (MulDivStartE) w_state_next = w_fast ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (FlushE)
      w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= funct3E;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      if (w_fast) begin
        r_result <= w_fast_result;
      end else begin
        r_cnt  <= CW'(W);
        r_acc  <= w_is_div ? {{W{1'b0}}, w_a_mag} : {{W{1'b0}}, w_b_mag};
        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
      end
    end else if (r_state == S_CALC && !FlushE) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1))
        r_result <= w_calc_result;
    end
  end

  assign MulDivResultE = r_result;
  assign MulDivDoneE   = (r_state == S_DONE);
  assign MulDivBusyE   = (r_state != S_IDLE);
  assign MulDivStallE  = w_accept | (r_state == S_CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table through a scoreboard queue,
// plus hand sequences for flush, async reset and back-to-back starts.
module tb_ex_muldiv_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    funct3;
  logic [DW-1:0] src_a, src_b;
  logic          flush;
  logic [DW-1:0] result;
  logic          done, stall, busy;

  ex_muldiv_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .MulDivStartE(start), .funct3E(funct3),
    .SrcAE(src_a), .SrcBE(src_b), .FlushE(flush),
    .MulDivResultE(result), .MulDivDoneE(done),
    .MulDivStallE(stall), .MulDivBusyE(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic run_op(input int idx, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int d = fast ? 1 : DW + 1;
    int done_cnt = 0;
    int done_at = -1;
    bit stall_bad = 0;
    bit busy_bad = 0;
    logic [31:0] e;
    string nm;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; src_a = a; src_b = b;
    sb_q.push_back(exp);
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      if (stall !== (c < d)) stall_bad = 1;
      if (busy !== (c > 0)) busy_bad = 1;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          nm = $sformatf("vec%0d_f3=%0d_result", idx, f3);
          check(nm, result, e);
        end
      end
      @(posedge clk); #1;
      if (c == d) start = 1'b0;
      else begin
        src_a = $urandom; src_b = $urandom; funct3 = 3'($urandom);
      end
    end
    $display("op vec%0d f3=%0d a=%h b=%h -> result=%h done_at=%0d", idx, f3, a, b, result, done_at);
    check($sformatf("vec%0d_done_cycle", idx), 32'(done_at), 32'(d));
    check($sformatf("vec%0d_done_count", idx), 32'(done_cnt), 32'd1);
    check($sformatf("vec%0d_stall_pattern", idx), 32'(stall_bad), 32'd0);
    check($sformatf("vec%0d_busy_pattern", idx), 32'(busy_bad), 32'd0);
    check($sformatf("vec%0d_scoreboard_drained", idx), 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    int done_at, done_cnt, done_at2;
    logic [31:0] e;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[10] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[11] = '{3'b011, 32'h80000000, 32'd2,        32'd1,        1'b0};
    vecs[12] = '{3'b000, 32'h12345678, 32'd16,       32'h23456780, 1'b0};
    vecs[13] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[14] = '{3'b111, 32'd5,        32'd0,        32'd5,        1'b1};
    vecs[15] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[16] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[17] = '{3'b101, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[18] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1};
    vecs[19] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[20] = '{3'b111, 32'hFFFFFFFF, 32'd16,       32'd15,       1'b0};
    vecs[21] = '{3'b010, 32'd2,        32'hFFFFFFFF, 32'd1,        1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; src_a = '0; src_b = '0;
    #3;
    check("reset_result", result, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++)
      run_op(i, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);

    // Flush in cycle 10 of a DIVU, then a MUL started in cycle 11
    done_cnt = 0; done_at = -1;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    check("flush_done_suppressed", 32'(done_cnt), 32'd0);
    check("flush_stall_c11", 32'(stall), 32'd0);
    check("flush_busy_c11", 32'(busy), 32'd0);
    #1;
    start = 1'b1; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4;
    sb_q.push_back(32'd12);
    for (int c = 12; c <= 44; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        e = sb_q.pop_front();
        check("flush_then_mul_result", result, e);
      end
    end
    @(posedge clk); #1; start = 1'b0;
    $display("op flush-then-MUL 3x4 -> result=%h done_at=%0d", result, done_at);
    check("flush_then_mul_done_cycle", 32'(done_at), 32'd44);
    check("flush_then_mul_done_count", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1; start = 1'b0;
    #1;
    $display("op async reset mid-CALC -> result=%h done=%b busy=%b stall=%b", result, done, busy, stall);
    check("async_rst_result", result, 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start held through DONE: one pulse, then the next op starts the cycle after DONE
    done_cnt = 0; done_at = -1; done_at2 = -1;
    sb_q.delete();
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4;
    sb_q.push_back(32'd12);
    for (int c = 0; c <= 67; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c; else done_at2 = c;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check($sformatf("b2b_result_c%0d", c), result, e);
        end
      end
      if (c == 33) check("b2b_stall_done", 32'(stall), 32'd0);
      if (c == 34) begin
        check("b2b_stall_restart", 32'(stall), 32'd1);
        check("b2b_busy_restart", 32'(busy), 32'd0);
      end
      if (c == 35) check("b2b_busy_calc", 32'(busy), 32'd1);
      @(posedge clk); #1;
      if (c == 32) begin
        funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
        sb_q.push_back(32'd14);
      end
    end
    start = 1'b0;
    $display("op back-to-back MUL/DIVU -> done_at=%0d,%0d result=%h", done_at, done_at2, result);
    check("b2b_first_done", 32'(done_at), 32'd33);
    check("b2b_second_done", 32'(done_at2), 32'd67);
    check("b2b_done_count", 32'(done_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
